// File: rtl/fifo_pkg.sv
// Shared defaults and op-type encoding for the block-RAM FIFO controller.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH    = 4;
  localparam int DEF_ADDRESS_WIDTH = 4;
  localparam int DEF_DEPTH         = 11;

  // The storage RAM runs at most one operation per cycle, so one code covers it.
  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_WR   = 2'd1,
    OP_RD   = 2'd2
  } op_e;

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Registered FIFO pointer that advances on enable and wraps from DEPTH-1 to 0.
module fifo_ptr_wrap
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [WIDTH-1:0] ptr_o
);

  logic [WIDTH-1:0] ptr_q;
  logic [WIDTH-1:0] ptr_d;

  // Next pointer: modulo-DEPTH increment, so a non-power-of-two depth never reaches DEPTH.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == WIDTH'(DEPTH - 1)) ? '0 : ptr_q + WIDTH'(1);
    end
  end

  // Pointer register with asynchronous reset to entry 0.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Control end of the block-RAM FIFO: arbitrates push/pop onto a single-port
// storage RAM, keeps wrap-around pointers, occupancy and flags, and returns
// read data with a one-cycle-late valid strobe.
module bram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DEPTH         = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_WIDTH-1:0]    push_data,
  output logic                     push_ready,
  input  logic                     pop,
  output logic                     pop_ready,
  output logic                     pop_valid,
  output logic [DATA_WIDTH-1:0]    pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [ADDRESS_WIDTH-1:0] count,
  output logic                     ram_cs,
  output logic                     ram_we,
  output logic                     ram_oe,
  output logic [ADDRESS_WIDTH-1:0] ram_addr_wr,
  output logic [ADDRESS_WIDTH-1:0] ram_addr_rd,
  output logic [DATA_WIDTH-1:0]    ram_din,
  input  logic [DATA_WIDTH-1:0]    ram_dout
);

  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr;
  logic [ADDRESS_WIDTH-1:0] last_rd_q;
  logic [ADDRESS_WIDTH-1:0] last_rd_d;
  logic [ADDRESS_WIDTH-1:0] count_q;
  logic [ADDRESS_WIDTH-1:0] count_d;
  logic                     pop_valid_q;
  logic                     pop_valid_d;
  logic                     pref_wr_q;   // 1: write wins the next contested cycle
  logic                     pref_wr_d;
  logic                     wr_ok;
  logic                     rd_ok;
  op_e                      op;

  assign full  = (count_q == ADDRESS_WIDTH'(DEPTH));
  assign empty = (count_q == '0);
  assign wr_ok = push & ~full;
  assign rd_ok = pop & ~empty;

  // Grant-preference register; comes out of reset favouring writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pref_wr_q <= 1'b1;
    else     pref_wr_q <= pref_wr_d;
  end

  // Arbitration: a lone eligible request wins; a contested cycle goes to the
  // preferred side and hands preference to the other side.
  always_comb begin
    op        = OP_IDLE;
    pref_wr_d = pref_wr_q;
    if (wr_ok && rd_ok) begin
      op        = pref_wr_q ? OP_WR : OP_RD;
      pref_wr_d = ~pref_wr_q;
    end else if (wr_ok) begin
      op = OP_WR;
    end else if (rd_ok) begin
      op = OP_RD;
    end
  end

  // RAM strobes and handshakes for the granted op. The RAM read path sources
  // its array through the write-address port, so reads drive rd_ptr on both.
  always_comb begin
    push_ready  = 1'b0;
    pop_ready   = 1'b0;
    ram_cs      = 1'b0;
    ram_we      = 1'b0;
    ram_oe      = 1'b0;
    ram_addr_wr = wr_ptr;
    ram_addr_rd = last_rd_q;
    ram_din     = push_data;
    unique case (op)
      OP_WR: begin
        push_ready = 1'b1;
        ram_cs     = 1'b1;
        ram_we     = 1'b1;
      end
      OP_RD: begin
        pop_ready   = 1'b1;
        ram_cs      = 1'b1;
        ram_oe      = 1'b1;
        ram_addr_wr = rd_ptr;
        ram_addr_rd = rd_ptr;
      end
      default: ;
    endcase
  end

  // Occupancy, last read address and read-valid bookkeeping for the granted op.
  always_comb begin
    count_d     = count_q;
    last_rd_d   = last_rd_q;
    pop_valid_d = 1'b0;
    if (op == OP_WR) begin
      count_d = count_q + ADDRESS_WIDTH'(1);
    end else if (op == OP_RD) begin
      count_d     = count_q - ADDRESS_WIDTH'(1);
      last_rd_d   = rd_ptr;
      pop_valid_d = 1'b1;
    end
  end

  // Bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the storage RAM itself is never cleared; resetting pointers and count is what discards its contents.
    if (rst) begin
      count_q     <= '0;
      last_rd_q   <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      last_rd_q   <= last_rd_d;
      pop_valid_q <= pop_valid_d;
    end
  end

  fifo_ptr_wrap #(
    .WIDTH (ADDRESS_WIDTH),
    .DEPTH (DEPTH)
  ) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (op == OP_WR),
    .ptr_o (wr_ptr)
  );

  fifo_ptr_wrap #(
    .WIDTH (ADDRESS_WIDTH),
    .DEPTH (DEPTH)
  ) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (op == OP_RD),
    .ptr_o (rd_ptr)
  );

  assign count     = count_q;
  assign pop_valid = pop_valid_q;
  assign pop_data  = ram_dout;

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed, table-driven bench for bram_fifo_ctrl with a behavioural
// single-port storage RAM (registered read through the write-address port).
module tb_bram_fifo_ctrl;

  localparam int DW = 4;
  localparam int AW = 4;
  localparam int DEPTH = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          push;
  logic [DW-1:0] push_data;
  logic          push_ready;
  logic          pop;
  logic          pop_ready;
  logic          pop_valid;
  logic [DW-1:0] pop_data;
  logic          full;
  logic          empty;
  logic [AW-1:0] count;
  logic          ram_cs;
  logic          ram_we;
  logic          ram_oe;
  logic [AW-1:0] ram_addr_wr;
  logic [AW-1:0] ram_addr_rd;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic [DW-1:0] mem [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_data   (push_data),
    .push_ready  (push_ready),
    .pop         (pop),
    .pop_ready   (pop_ready),
    .pop_valid   (pop_valid),
    .pop_data    (pop_data),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .ram_cs      (ram_cs),
    .ram_we      (ram_we),
    .ram_oe      (ram_oe),
    .ram_addr_wr (ram_addr_wr),
    .ram_addr_rd (ram_addr_rd),
    .ram_din     (ram_din),
    .ram_dout    (ram_dout)
  );

  // Storage RAM model: one op per cycle, read data registered.
  always @(posedge clk) begin
    if (ram_cs && ram_we)      mem[ram_addr_wr] <= ram_din;
    else if (ram_cs && ram_oe) ram_dout <= mem[ram_addr_wr];
  end

  typedef struct {
    logic          push;
    logic [DW-1:0] din;
    logic          pop;
    logic          e_pr;     // expected push_ready
    logic          e_por;    // expected pop_ready
    logic [AW-1:0] e_awr;    // expected ram_addr_wr
    logic [AW-1:0] e_ard;    // expected ram_addr_rd
    logic [AW-1:0] e_cnt;    // expected count after the edge
    logic          e_pv;     // expected pop_valid after the edge
    logic [DW-1:0] e_pd;     // expected pop_data after the edge (when e_pv)
  } vec_t;

  vec_t vq[$];
  int   vec_no = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  function automatic void add(input logic p, input logic [DW-1:0] d, input logic q,
                              input logic pr, input logic por, input int awr, input int ard,
                              input int cnt, input logic pv, input int pd);
    vec_t v;
    v.push = p; v.din = d; v.pop = q; v.e_pr = pr; v.e_por = por;
    v.e_awr = AW'(awr); v.e_ard = AW'(ard); v.e_cnt = AW'(cnt);
    v.e_pv = pv; v.e_pd = DW'(pd);
    vq.push_back(v);
  endfunction

  task automatic run_vecs();
    foreach (vq[k]) begin
      @(negedge clk);
      push = vq[k].push; push_data = vq[k].din; pop = vq[k].pop;
      #1;
      check("push_ready", vec_no, 32'(push_ready), 32'(vq[k].e_pr));
      check("pop_ready", vec_no, 32'(pop_ready), 32'(vq[k].e_por));
      check("ram_cs", vec_no, 32'(ram_cs), 32'(vq[k].e_pr | vq[k].e_por));
      check("ram_we", vec_no, 32'(ram_we), 32'(vq[k].e_pr));
      check("ram_oe", vec_no, 32'(ram_oe), 32'(vq[k].e_por));
      check("ram_addr_wr", vec_no, 32'(ram_addr_wr), 32'(vq[k].e_awr));
      check("ram_addr_rd", vec_no, 32'(ram_addr_rd), 32'(vq[k].e_ard));
      if (vq[k].e_pr) check("ram_din", vec_no, 32'(ram_din), 32'(vq[k].din));
      @(posedge clk);
      #1;
      check("count", vec_no, 32'(count), 32'(vq[k].e_cnt));
      check("full", vec_no, 32'(full), 32'(vq[k].e_cnt == AW'(DEPTH)));
      check("empty", vec_no, 32'(empty), 32'(vq[k].e_cnt == '0));
      check("pop_valid", vec_no, 32'(pop_valid), 32'(vq[k].e_pv));
      if (vq[k].e_pv) check("pop_data", vec_no, 32'(pop_data), 32'(vq[k].e_pd));
      vec_no++;
    end
    vq.delete();
    push = 1'b0;
    pop  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 0, 32'(count), 32'd0);
    check("rst_empty", 0, 32'(empty), 32'd1);
    check("rst_full", 0, 32'(full), 32'd0);
    check("rst_pop_valid", 0, 32'(pop_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fill with 0x1..0xB.
    for (int i = 0; i < 11; i++) add(1, DW'(i + 1), 0, 1, 0, i, 0, i + 1, 0, 0);
    // Push while full is refused; wr_ptr has wrapped to 0.
    add(1, 4'hF, 0, 0, 0, 0, 0, 11, 0, 0);
    // Drain in order.
    for (int i = 0; i < 11; i++) add(0, 4'h0, 1, 0, 1, i, i, 10 - i, 1, i + 1);
    // Pop while empty is refused; read-out address holds the last read.
    add(0, 4'h0, 1, 0, 0, 0, 10, 0, 0, 0);
    run_vecs();

    // Wrap: push 0xF..0x5, pop 5, push 3 across the wrap, pop 9.
    for (int i = 0; i < 11; i++) add(1, DW'(15 - i), 0, 1, 0, i, 10, i + 1, 0, 0);
    for (int i = 0; i < 5; i++)  add(0, 4'h0, 1, 0, 1, i, i, 10 - i, 1, 15 - i);
    for (int i = 0; i < 3; i++)  add(1, DW'(i + 1), 0, 1, 0, i, 4, 7 + i, 0, 0);
    for (int i = 0; i < 6; i++)  add(0, 4'h0, 1, 0, 1, 5 + i, 5 + i, 8 - i, 1, 10 - i);
    for (int i = 0; i < 3; i++)  add(0, 4'h0, 1, 0, 1, i, i, 2 - i, 1, i + 1);
    run_vecs();

    // Contested: prefill 4 (wr_ptr 3..6), then push+pop for 6 cycles.
    for (int i = 0; i < 4; i++) add(1, DW'(i + 1), 0, 1, 0, 3 + i, 2, i + 1, 0, 0);
    add(1, 4'h5, 1, 1, 0, 7, 2, 5, 0, 0);
    add(1, 4'h6, 1, 0, 1, 3, 3, 4, 1, 1);
    add(1, 4'h6, 1, 1, 0, 8, 3, 5, 0, 0);
    add(1, 4'h7, 1, 0, 1, 4, 4, 4, 1, 2);
    add(1, 4'h7, 1, 1, 0, 9, 4, 5, 0, 0);
    add(1, 4'h8, 1, 0, 1, 5, 5, 4, 1, 3);
    for (int i = 0; i < 4; i++) add(0, 4'h0, 1, 0, 1, 6 + i, 6 + i, 3 - i, 1, 4 + i);
    run_vecs();

    // Edge priority: empty with push+pop -> write; full with push+pop -> read.
    add(1, 4'h9, 1, 1, 0, 10, 9, 1, 0, 0);
    for (int i = 0; i < 10; i++) add(1, DW'(i), 0, 1, 0, i, 9, 2 + i, 0, 0);
    add(1, 4'hF, 1, 0, 1, 10, 10, 10, 1, 9);
    for (int i = 0; i < 3; i++) add(0, 4'h0, 1, 0, 1, i, i, 9 - i, 1, i);
    run_vecs();

    // Async reset between edges with count=7 and pop_valid=1.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_count", vec_no, 32'(count), 32'd0);
    check("arst_empty", vec_no, 32'(empty), 32'd1);
    check("arst_full", vec_no, 32'(full), 32'd0);
    check("arst_pop_valid", vec_no, 32'(pop_valid), 32'd0);
    #1 rst = 1'b0;

    // Recovery from entry 0.
    add(1, 4'hA, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 4'h0, 1, 0, 1, 0, 0, 0, 1, 10);
    run_vecs();

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_fifo_ctrl.md
Name: bram_fifo_ctrl

Overview:
- Control and handshake end of the block-RAM FIFO.
- Turns push/pop requests into chip-select, write-enable, output-enable and write/read address strobes for the 11-entry FIFO storage RAM.
- Keeps wrap-around pointers, occupancy count and full/empty flags, and returns read data with a valid strobe.
- The storage RAM allows one operation per cycle, write or read, so this block arbitrates between simultaneous push and pop.

Parameters:
- DATA_WIDTH, 4: FIFO word width; equals RAM data width.
- ADDRESS_WIDTH, 4: RAM address width.
- DEPTH, 11: number of RAM entries used. Constraint: DEPTH <= 2**ADDRESS_WIDTH - 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- push  in  1  write request.
- push_data  in  DATA_WIDTH  word to enqueue.
- push_ready  out  1  push accepted this cycle (combinational).
- pop  in  1  read request.
- pop_ready  out  1  pop accepted this cycle (combinational).
- pop_valid  out  1  pop_data valid; registered, one cycle after pop accept.
- pop_data  out  DATA_WIDTH  dequeued word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  ADDRESS_WIDTH  occupancy, 0..DEPTH.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_oe  out  1  RAM output enable.
- ram_addr_wr  out  ADDRESS_WIDTH  RAM write/source address.
- ram_addr_rd  out  ADDRESS_WIDTH  RAM read-out address.
- ram_din  out  DATA_WIDTH  RAM write data.
- ram_dout  in  DATA_WIDTH  RAM read data.

Behaviour:
- Reset (async, any time, including mid-operation):
  - wr_ptr=0, rd_ptr=0, last_rd=0, count=0.
  - empty=1, full=0, pop_valid=0, pop_data reflects ram_dout.
  - Grant preference = write.
  - RAM contents are not cleared; they are treated as discarded.
- Eligibility: wr_ok = push & !full; rd_ok = pop & !empty.
- Arbitration:
  - If only one of wr_ok/rd_ok is set, it wins.
  - If both are set, the preferred side wins and preference flips to the other side. Preference only changes on a contested cycle.
  - push_ready = write granted; pop_ready = read granted.
  - Requester holds push/pop and data until its ready is seen.
- Write op (same cycle, combinational to RAM):
  - ram_cs=1, ram_we=1, ram_oe=0, ram_addr_wr=wr_ptr, ram_din=push_data.
  - At the clock edge: wr_ptr advances, count+1.
- Read op:
  - ram_cs=1, ram_we=0, ram_oe=1, ram_addr_wr=rd_ptr, ram_addr_rd=rd_ptr. The RAM read path sources its array through the write-address port, so both addresses carry rd_ptr.
  - At the clock edge: last_rd<=rd_ptr, rd_ptr advances, count-1, pop_valid<=1.
- Idle, or neither request eligible:
  - ram_cs=0, ram_we=0, ram_oe=0, ram_addr_wr=wr_ptr, ram_addr_rd=last_rd, ram_din=push_data.
  - pop_valid<=0.
- pop_data:
  - pop_data = ram_dout, with ram_addr_rd held at last_rd outside read cycles.
  - Valid exactly when pop_valid=1, one cycle after accept.
  - Back-to-back reads give pop_valid high on consecutive cycles.
- Pointer wrap: next = (ptr == DEPTH-1) ? 0 : ptr+1. Non-power-of-two wrap; never reaches DEPTH.
- count changes by at most ±1 per cycle, since only one op runs per cycle. Never exceeds DEPTH, never underflows.
- Full: push is ignored (push_ready=0). A pop in the same cycle is granted regardless of preference.
- Empty: pop is ignored. A write in the same cycle is granted; no read-through of the word being written.
- Throughput: a sustained push+pop pair alternates and gives 0.5 op each per cycle.

Decomposition:
- Shared package fifo_pkg:
  - Default DATA_WIDTH, ADDRESS_WIDTH, DEPTH.
  - Op-type encoding constants OP_IDLE, OP_WR, OP_RD.
- One sub-module, fifo_ptr_wrap:
  - Registered pointer with enable, modulo-DEPTH increment and async reset.
  - Instantiated twice, for wr_ptr and rd_ptr.
- Arbiter, count and flags stay in bram_fifo_ctrl.

Test Plan:
- Reset, then push 11 words 0x1..0xB on consecutive cycles -> push_ready=1 each cycle; count 1..11; full=1 after the 11th; ram_addr_wr 0..10.
- With full=1, push 0xF -> push_ready=0; no RAM write strobe; count stays 11. Then pop 11 times -> pop_data 0x1..0xB, each one cycle after its pop_ready; empty=1 at end; pop while empty -> pop_ready=0, pop_valid=0.
- Wrap: push 11, pop 5, push 3 -> wr_ptr goes 10->0->1->2; then pop 9 -> data order intact (0x6..0xB, then the 3 new words).
- Contested: count=4, push and pop held high 6 cycles -> grants alternate W,R,W,R,W,R; count ends at 4; data order intact.
- Edge priority: count=0 with push+pop -> write granted, pop_valid stays 0. count=11 with push+pop -> read granted.
- Async reset mid-stream: assert rst between edges with count=7 -> count=0, empty=1, pop_valid=0 immediately. After release, push 0xA then pop -> pop_data=0xA.
